// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between pipeline stages: valid/ready plus control, data lanes and destination register.
// The master drives the entry; the slave returns ready.
interface pipe_stage_reg_if #(
    parameter int CTRL_W   = 4,
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 2,
    parameter int RADDR_W  = 5
);
    logic                         valid;
    logic                         ready;
    logic [CTRL_W-1:0]            ctrl;
    logic [NUM_DATA*DATA_W-1:0]   data;
    logic [RADDR_W-1:0]           rd;

    modport master (output valid, ctrl, data, rd, input  ready);
    modport slave  (input  valid, ctrl, data, rd, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register with flush, bubble-gated control and a saturating bubble counter; 1-cycle latency.
// Backpressure: SKID=1 holds a second entry behind a registered ready, SKID=0 single entry with combinational ready.
module pipe_stage_reg #(
    parameter int CTRL_W   = 4,
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 2,
    parameter int RADDR_W  = 5,
    parameter int SKID     = 1
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Flush,
    pipe_stage_reg_if.slave     in_if,
    pipe_stage_reg_if.master    out_if,
    output logic [15:0]         Bubble_count
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_MAIN  = 2'd1;
    localparam logic [1:0] ST_BOTH  = 2'd2;

    typedef struct packed {
        logic [CTRL_W-1:0]          ctrl;
        logic [NUM_DATA*DATA_W-1:0] data;
        logic [RADDR_W-1:0]         rd;
    } entry_t;

    logic [1:0]  state_q, state_d;
    entry_t      main_q, main_d;
    entry_t      skid_q, skid_d;
    logic [15:0] bubble_q, bubble_d;

    entry_t in_ent;
    logic   out_valid;
    logic   in_ready;
    logic   accept;
    logic   issue;

    assign in_ent    = '{ctrl: in_if.ctrl, data: in_if.data, rd: in_if.rd};
    assign out_valid = (state_q != ST_EMPTY);

    // With a skid entry, ready depends only on state so it never combinationally follows Out_ready.
    assign in_ready  = (SKID != 0) ? (state_q != ST_BOTH) : (out_if.ready | ~out_valid);
    assign accept    = in_if.valid & in_ready;
    assign issue     = out_valid & out_if.ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (Flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_MAIN;
                        main_d  = in_ent;
                    end
                end
                ST_MAIN: begin
                    if (issue && accept) begin
                        main_d = in_ent;
                    end else if (issue) begin
                        state_d = ST_EMPTY;
                    end else if (accept && (SKID != 0)) begin
                        state_d = ST_BOTH;
                        skid_d  = in_ent;
                    end
                end
                ST_BOTH: begin
                    if (issue) begin
                        state_d = ST_MAIN;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Counting ignores Flush; only reset clears the counter.
    always_comb begin
        bubble_d = bubble_q;
        if (!out_valid && (bubble_q != 16'hFFFF)) begin
            bubble_d = bubble_q + 16'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q  <= ST_EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            bubble_q <= bubble_d;
        end
    end

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.ctrl  = out_valid ? main_q.ctrl : '0;
    assign out_if.data  = main_q.data;
    assign out_if.rd    = main_q.rd;
    assign Bubble_count = bubble_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=1 instance (a) and one SKID=0 instance (b).
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [15:0] bub_a, bub_b;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if a_in ();
    pipe_stage_reg_if a_out ();
    pipe_stage_reg_if b_in ();
    pipe_stage_reg_if b_out ();

    pipe_stage_reg #(.SKID(1)) u_a (
        .Clock(clk), .Reset_n(rst_n), .Flush(flush),
        .in_if(a_in), .out_if(a_out), .Bubble_count(bub_a)
    );
    pipe_stage_reg #(.SKID(0)) u_b (
        .Clock(clk), .Reset_n(rst_n), .Flush(flush),
        .in_if(b_in), .out_if(b_out), .Bubble_count(bub_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drv_a(input logic v, input logic [4:0] rd, input logic [3:0] ctrl);
        a_in.valid = v;
        a_in.rd    = rd;
        a_in.ctrl  = ctrl;
        a_in.data  = {32'h0, 27'h0, rd};
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drv_a(1'b0, 5'd0, 4'd0);
        a_out.ready = 1'b1;
        b_in.valid = 1'b0; b_in.rd = '0; b_in.ctrl = '0; b_in.data = '0;
        b_out.ready = 1'b1;

        // Reset state
        nxt(); nxt();
        smp();
        chk("rst_vld",  a_out.valid, 0);
        chk("rst_ctrl", a_out.ctrl, 0);
        chk("rst_data", a_out.data[31:0], 0);
        chk("rst_rd",   a_out.rd, 0);
        chk("rst_bub",  bub_a, 0);
        chk("rst_rdy_a", a_in.ready, 1);
        chk("rst_rdy_b", b_in.ready, 1);
        nxt();
        rst_n = 1'b1;
        nxt();
        smp();
        chk("bub_rel", bub_a, 1);
        chk("rel_vld", a_out.valid, 0);
        nxt();

        // Back-to-back stream rd=1..8
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                a_in.valid = 1'b1;
                a_in.rd    = 5'(i + 1);
                a_in.ctrl  = 4'b0001;
                a_in.data  = {32'h0, 32'(32'h10 + i)};
            end else begin
                a_in.valid = 1'b0;
            end
            smp();
            chk("strm_rdy", a_in.ready, 1);
            if (i > 0) begin
                chk("strm_vld", a_out.valid, 1);
                chk("strm_rd",  a_out.rd, i);
                chk("strm_d0",  a_out.data[31:0], 32'(32'h10 + i - 1));
            end
            if (i == 8) chk("bub_strm", bub_a, 3);
            nxt();
        end

        // Bubble gating of control
        drv_a(1'b0, 5'd0, 4'b1111);
        smp();
        chk("gate_ctrl", a_out.ctrl, 0);
        chk("gate_vld",  a_out.valid, 0);
        nxt();
        drv_a(1'b1, 5'd9, 4'b1001);
        nxt();
        drv_a(1'b0, 5'd0, 4'b1111);
        smp();
        chk("acc_ctrl", a_out.ctrl, 4'b1001);
        chk("acc_rd",   a_out.rd, 9);
        nxt();
        smp();
        chk("after_ctrl", a_out.ctrl, 0);
        nxt();

        // Stall into skid entry
        drv_a(1'b1, 5'd3, 4'b0010);
        nxt();
        drv_a(1'b1, 5'd4, 4'b0010);
        a_out.ready = 1'b0;
        smp();
        chk("stl_rdy_main", a_in.ready, 1);
        chk("stl_rd3", a_out.rd, 3);
        nxt();
        drv_a(1'b1, 5'd5, 4'b0010);
        smp();
        chk("stl_rdy_both", a_in.ready, 0);
        chk("stl_hold3", a_out.rd, 3);
        nxt();
        drv_a(1'b0, 5'd0, 4'b0000);
        smp();
        chk("stl_rdy_both2", a_in.ready, 0);
        nxt();
        a_out.ready = 1'b1;
        smp();
        chk("stl_iss3", a_out.rd, 3);
        chk("stl_rdy_iss", a_in.ready, 0);
        nxt();
        smp();
        chk("stl_iss4", a_out.rd, 4);
        chk("stl_vld4", a_out.valid, 1);
        chk("stl_rdy_after", a_in.ready, 1);
        nxt();
        smp();
        chk("stl_empty", a_out.valid, 0);
        nxt();

        // Flush while both entries held
        a_out.ready = 1'b0;
        drv_a(1'b1, 5'd5, 4'b0100);
        nxt();
        drv_a(1'b1, 5'd6, 4'b0100);
        nxt();
        drv_a(1'b1, 5'd7, 4'b0100);
        flush = 1'b1;
        smp();
        chk("fl_both_rd", a_out.rd, 5);
        nxt();
        flush = 1'b0;
        drv_a(1'b0, 5'd0, 4'b0000);
        smp();
        chk("fl_vld", a_out.valid, 0);
        chk("fl_ctrl", a_out.ctrl, 0);
        nxt();
        a_out.ready = 1'b1;
        smp();
        chk("fl_no7", a_out.valid, 0);
        nxt();

        // Flush with simultaneous issue and accept
        drv_a(1'b1, 5'd10, 4'b0100);
        nxt();
        drv_a(1'b1, 5'd11, 4'b0100);
        flush = 1'b1;
        smp();
        chk("fli_vld", a_out.valid, 1);
        chk("fli_rd",  a_out.rd, 10);
        nxt();
        flush = 1'b0;
        drv_a(1'b0, 5'd0, 4'b0000);
        smp();
        chk("fli_empty", a_out.valid, 0);
        nxt();

        // SKID=0 instance: combinational ready and replace-per-cycle
        b_in.valid = 1'b1; b_in.rd = 5'd20;
        nxt();
        b_in.rd = 5'd21;
        b_out.ready = 1'b0;
        smp();
        chk("b_rdy_stall", b_in.ready, 0);
        chk("b_rd20", b_out.rd, 20);
        nxt();
        b_out.ready = 1'b1;
        smp();
        chk("b_rdy_go", b_in.ready, 1);
        chk("b_rd20_hold", b_out.rd, 20);
        nxt();
        b_in.rd = 5'd22;
        smp();
        chk("b_rd21", b_out.rd, 21);
        nxt();
        b_in.valid = 1'b0;
        smp();
        chk("b_rd22", b_out.rd, 22);
        nxt();
        smp();
        chk("b_empty", b_out.valid, 0);
        nxt();

        // Bubble counter saturation
        repeat (70000) @(posedge clk);
        #1;
        smp();
        chk("bub_sat", bub_a, 16'hFFFF);
        nxt(); nxt();
        smp();
        chk("bub_sat_hold", bub_a, 16'hFFFF);
        nxt();

        // Reset while in BOTH state
        a_out.ready = 1'b0;
        drv_a(1'b1, 5'd12, 4'b1000);
        nxt();
        drv_a(1'b1, 5'd13, 4'b1000);
        nxt();
        drv_a(1'b0, 5'd0, 4'b0000);
        smp();
        chk("mr_both", a_in.ready, 0);
        nxt();
        rst_n = 1'b0;
        nxt();
        smp();
        chk("mr_vld", a_out.valid, 0);
        chk("mr_rd",  a_out.rd, 0);
        chk("mr_bub", bub_a, 0);
        chk("mr_rdy", a_in.ready, 1);
        nxt();
        rst_n = 1'b1;
        a_out.ready = 1'b1;
        nxt(); nxt();
        smp();
        chk("mr_lost", a_out.valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
